// File: rtl/mips_pkg.sv
// Shared decode constants, FSM state type and boot address for the MIPS bus core.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALTED} state_e;

endpackage

// File: rtl/mips_regfile.sv
// 32x32 general-purpose register file: two combinational read ports, one
// clocked write port, $0 forced to zero, and a direct tap on $2 (v0).
module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra_addr,
  output logic [31:0] ra_data,
  input  logic [4:0]  rb_addr,
  output logic [31:0] rb_data,
  input  logic        we,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  output logic [31:0] v0
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    for (int i = 0; i < 32; i++) regs_d[i] = regs_q[i];
    if (we && (w_addr != 5'd0)) regs_d[w_addr] = w_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign ra_data = (ra_addr == 5'd0) ? 32'h0 : regs_q[ra_addr];
  assign rb_data = (rb_addr == 5'd0) ? 32'h0 : regs_q[rb_addr];
  assign v0      = regs_q[2];

endmodule

// File: rtl/mips_cpu_bus_core.sv
// Multicycle MIPS32 subset core sharing one Avalon-style port between fetch and
// data access; stops once the delay slot of a jump to address 0 has executed.
module mips_cpu_bus_core
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, npc_q, npc_d, ir_q, ir_d, addr_q, addr_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] simm, rs_val, rt_val;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  mips_regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (rs),
    .ra_data (rs_val),
    .rb_addr (rt),
    .rb_data (rt_val),
    .we      (rf_we),
    .w_addr  (rf_waddr),
    .w_data  (rf_wdata),
    .v0      (register_v0)
  );

  logic        is_jr, is_lw, is_sw;
  logic        alu_we;
  logic [4:0]  alu_dst;
  logic [31:0] alu_res, eff_addr;

  assign is_jr    = (opcode == OP_SPECIAL) && (funct == FN_JR);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign eff_addr = rs_val + simm;

  always_comb begin
    alu_we  = 1'b0;
    alu_dst = rd;
    alu_res = '0;
    case (opcode)
      OP_SPECIAL: begin
        alu_we = 1'b1;
        case (funct)
          FN_SLL:  alu_res = rt_val << shamt;
          FN_SRL:  alu_res = rt_val >> shamt;
          FN_SRA:  alu_res = $unsigned($signed(rt_val) >>> shamt);
          FN_SLLV: alu_res = rt_val << rs_val[4:0];
          FN_SRLV: alu_res = rt_val >> rs_val[4:0];
          FN_SRAV: alu_res = $unsigned($signed(rt_val) >>> rs_val[4:0]);
          FN_ADDU: alu_res = rs_val + rt_val;
          FN_SUBU: alu_res = rs_val - rt_val;
          FN_AND:  alu_res = rs_val & rt_val;
          FN_OR:   alu_res = rs_val | rt_val;
          FN_XOR:  alu_res = rs_val ^ rt_val;
          FN_SLT:  alu_res = {31'b0, $signed(rs_val) < $signed(rt_val)};
          FN_SLTU: alu_res = {31'b0, rs_val < rt_val};
          default: alu_we = 1'b0;  // JR and unknown functs write nothing
        endcase
      end
      OP_ADDIU: begin
        alu_we  = 1'b1;
        alu_dst = rt;
        alu_res = rs_val + simm;
      end
      OP_LUI: begin
        alu_we  = 1'b1;
        alu_dst = rt;
        alu_res = {ir_q[15:0], 16'h0};
      end
      default: ;
    endcase
  end

  logic        bus_read, bus_write;
  logic [31:0] bus_addr, bus_wdata;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    ir_d      = ir_q;
    addr_d    = addr_q;
    rf_we     = 1'b0;
    rf_waddr  = alu_dst;
    rf_wdata  = alu_res;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    bus_addr  = pc_q;
    bus_wdata = '0;
    case (state_q)
      FETCH: begin
        if (pc_q == 32'h0) begin
          state_d = HALTED;
        end else begin
          bus_read = 1'b1;
          if (!waitrequest) begin
            ir_d    = readdata;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        rf_we  = alu_we;
        pc_d   = npc_q;
        npc_d  = is_jr ? rs_val : npc_q + 32'd4;
        addr_d = {eff_addr[31:2], 2'b00};
        // Going straight to HALTED keeps address 0 from ever being fetched.
        if (is_lw || is_sw)          state_d = MEM;
        else if (npc_q == 32'h0)     state_d = HALTED;
        else                         state_d = FETCH;
      end
      MEM: begin
        bus_addr = addr_q;
        if (is_lw) begin
          bus_read = 1'b1;
        end else begin
          bus_write = 1'b1;
          bus_wdata = rt_val;
        end
        if (!waitrequest) begin
          rf_we    = is_lw;
          rf_waddr = rt;
          rf_wdata = readdata;
          state_d  = (pc_q == 32'h0) ? HALTED : FETCH;
        end
      end
      HALTED: ;
      default: state_d = HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_VECTOR;
      npc_q   <= RESET_VECTOR + 32'd4;
      ir_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
    end
  end

  // Strobes are qualified with reset so an in-flight access drops the moment reset asserts.
  assign active     = reset & (state_q != HALTED);
  assign read       = reset & bus_read;
  assign write      = reset & bus_write;
  assign address    = bus_addr;
  assign writedata  = bus_wdata;
  assign byteenable = 4'hF;

endmodule

// File: tb/tb_mips_cpu_bus_core.sv
// Bench for mips_cpu_bus_core: directed and random programs run on a stalling bus
// slave and compared against an instruction-level interpreter.
module tb_mips_cpu_bus_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active, write, read;
  logic        waitrequest = 1'b0;
  logic [31:0] register_v0, address, writedata;
  logic [31:0] readdata = 32'h0;
  logic [3:0]  byteenable;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_cpu_bus_core dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .register_v0 (register_v0),
    .address     (address),
    .write       (write),
    .read        (read),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  localparam logic [31:0] BOOT = 32'hBFC0_0000;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] prog [$];
  int          stall_cfg = 0;
  int          bad_cnt = 0;
  logic [31:0] ref_v0;
  int          ref_cycles, ref_accesses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Bus slave: each access stalls stall_cfg cycles, then completes.
  int          remaining = 0;
  bit          busy = 0, wr_pend = 0;
  logic        hold_read;
  logic [31:0] hold_addr, hold_wdata, wr_addr, wr_data;

  always @(negedge clk) begin
    if (read && write) bad_cnt++;
    if (read && address == 32'h0) bad_cnt++;
    if ((read || write) && address[1:0] != 2'b00) bad_cnt++;
    if (!reset) begin
      busy = 0; remaining = 0; waitrequest = 1'b0;
    end else if (read || write) begin
      if (!busy) begin
        busy = 1; remaining = stall_cfg;
        hold_addr = address; hold_read = read; hold_wdata = writedata;
      end else begin
        check("stall_addr", address, hold_addr);
        check("stall_read", 32'(read), 32'(hold_read));
        check("stall_wdata", writedata, hold_wdata);
      end
      if (remaining > 0) begin
        waitrequest = 1'b1;
        remaining--;
      end else begin
        waitrequest = 1'b0;
        busy = 0;
        readdata = read ? mem_rd(address) : 32'h0;
        if (write) begin
          check("store_be", 32'(byteenable), 32'hF);
          wr_pend = 1; wr_addr = address; wr_data = writedata;
        end
      end
    end else begin
      busy = 0; waitrequest = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (wr_pend && reset) mem[wr_addr] = wr_data;
    wr_pend = 0;
  end

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh,
                                        input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] sra(input logic [31:0] x, input int s);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    return (x >> s) | (x[31] ? ~(ones >> s) : 32'h0);
  endfunction

  task automatic load_prog();
    mem.delete();
    ref_mem.delete();
    foreach (prog[i]) begin
      mem[BOOT + 32'(4 * i)]     = prog[i];
      ref_mem[BOOT + 32'(4 * i)] = prog[i];
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  // Architectural interpreter: pc/npc pair, 2 cycles per instruction, +1 for memory ops.
  task automatic run_ref();
    logic [31:0] r [32];
    logic [31:0] pc, npc, ins, a, b, res, se, ea;
    int rs, rt, rd, sh, dst;
    bit wr;
    for (int i = 0; i < 32; i++) r[i] = 32'h0;
    pc = BOOT; npc = BOOT + 32'd4;
    ref_cycles = 0; ref_accesses = 0;
    for (int step = 0; step < 4000 && pc != 32'h0; step++) begin
      ins = ref_rd(pc);
      rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]); sh = int'(ins[10:6]);
      a = r[rs]; b = r[rt]; se = {{16{ins[15]}}, ins[15:0]};
      ea = (a + se) & 32'hFFFF_FFFC;
      pc = npc; npc = npc + 32'd4;
      ref_cycles += 2; ref_accesses += 1;
      wr = 0; dst = rd; res = 32'h0;
      case (ins[31:26])
        6'h00: begin
          wr = 1;
          case (ins[5:0])
            6'h00: res = b << sh;
            6'h02: res = b >> sh;
            6'h03: res = sra(b, sh);
            6'h04: res = b << a[4:0];
            6'h06: res = b >> a[4:0];
            6'h07: res = sra(b, int'(a[4:0]));
            6'h08: begin wr = 0; npc = a; end
            6'h21: res = a + b;
            6'h23: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h26: res = a ^ b;
            6'h2A: res = (a[31] != b[31]) ? 32'(a[31]) : 32'(a < b);
            6'h2B: res = 32'(a < b);
            default: wr = 0;
          endcase
        end
        6'h09: begin wr = 1; dst = rt; res = a + se; end
        6'h0F: begin wr = 1; dst = rt; res = {ins[15:0], 16'h0}; end
        6'h23: begin wr = 1; dst = rt; res = ref_rd(ea); ref_cycles++; ref_accesses++; end
        6'h2B: begin ref_mem[ea] = b; ref_cycles++; ref_accesses++; end
        default: ;
      endcase
      if (wr && dst != 0) r[dst] = res;
    end
    ref_v0 = r[2];
  endtask

  task automatic run_prog(input string tag, input int stall, input bit use_const,
                          input logic [31:0] const_v0);
    int cyc, mis;
    bit done;
    run_ref();
    stall_cfg = stall;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_rst_active"}, 32'(active), 32'h0);
    check({tag, "_rst_read"}, 32'(read), 32'h0);
    check({tag, "_rst_write"}, 32'(write), 32'h0);
    check({tag, "_rst_addr"}, address, BOOT);
    check({tag, "_rst_be"}, 32'(byteenable), 32'hF);
    check({tag, "_rst_wdata"}, writedata, 32'h0);
    check({tag, "_rst_v0"}, register_v0, 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    bad_cnt = 0;
    @(negedge clk);
    check({tag, "_boot_active"}, 32'(active), 32'h1);
    check({tag, "_boot_read"}, 32'(read), 32'h1);
    check({tag, "_boot_write"}, 32'(write), 32'h0);
    check({tag, "_boot_addr"}, address, BOOT);
    check({tag, "_boot_be"}, 32'(byteenable), 32'hF);
    cyc = 1; done = 0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (active) cyc++;
      else done = 1;
    end
    check({tag, "_halted"}, 32'(done), 32'h1);
    check({tag, "_v0"}, register_v0, use_const ? const_v0 : ref_v0);
    check({tag, "_cycles"}, 32'(cyc), 32'(ref_cycles + stall * ref_accesses));
    mis = (mem.num() != ref_mem.num()) ? 1 : 0;
    foreach (ref_mem[k]) if (!mem.exists(k) || mem[k] !== ref_mem[k]) mis++;
    check({tag, "_mem"}, 32'(mis), 32'h0);
    repeat (3) @(negedge clk);
    check({tag, "_stay_halted"}, 32'(active | read | write), 32'h0);
    check({tag, "_bus_rules"}, 32'(bad_cnt), 32'h0);
    $display("prog %s stall=%0d cycles=%0d v0=%h", tag, stall, cyc, register_v0);
  endtask

  function automatic int pick_src();
    int t;
    t = int'($urandom_range(0, 6));
    return (t == 0) ? 3 : ((t == 1) ? 0 : ((t < 3) ? 1 : t + 1));
  endfunction

  function automatic int pick_dst();
    int t;
    t = int'($urandom_range(0, 6));
    return (t == 0) ? 0 : ((t < 3) ? t : t + 1);
  endfunction

  function automatic logic [5:0] pick_fn();
    case ($urandom_range(0, 13))
      0: return 6'h00;  1: return 6'h02;  2: return 6'h03;  3: return 6'h04;
      4: return 6'h06;  5: return 6'h07;  6: return 6'h21;  7: return 6'h23;
      8: return 6'h24;  9: return 6'h25; 10: return 6'h26; 11: return 6'h2A;
      12: return 6'h2B;
      default: return 6'h3F;
    endcase
  endfunction

  task automatic gen_random(input int n);
    int kind;
    logic [15:0] off;
    prog.delete();
    prog.push_back(enc_i(6'h0F, 0, 3, 16'hBFC0));
    for (int r = 1; r < 8; r++) begin
      if (r == 3) continue;
      prog.push_back(enc_i(6'h0F, 0, r, 16'($urandom)));
      prog.push_back(enc_i(6'h09, r, r, 16'($urandom)));
    end
    for (int i = 0; i < n; i++) begin
      kind = int'($urandom_range(0, 9));
      off  = 16'h0200 + 16'(4 * $urandom_range(0, 7));
      case (kind)
        6:       prog.push_back(enc_i(6'h09, pick_src(), pick_dst(), 16'($urandom)));
        7:       prog.push_back(enc_i(6'h23, 3, pick_dst(), off));
        8:       prog.push_back(enc_i(6'h2B, 3, pick_src(), off));
        9:       prog.push_back({6'h3F, 26'($urandom)});
        default: prog.push_back(enc_r(pick_src(), pick_src(), pick_dst(),
                                      int'($urandom_range(0, 31)), pick_fn()));
      endcase
    end
    prog.push_back(enc_r(0, 0, 0, 0, 6'h08));
    prog.push_back(enc_r(pick_src(), pick_src(), 2, 0, 6'h21));
  endtask

  initial begin
    #5 reset = 1'b1;
    #1 reset = 1'b0;
    #200_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    #1;

    // srlv example: 0xC0 >> 5 = 6
    prog = '{enc_i(6'h0F, 0, 3, 16'hBFC0), enc_i(6'h23, 3, 9, 16'h0028),
             enc_i(6'h23, 3, 10, 16'h002C), enc_r(0, 0, 0, 0, 6'h08),
             enc_r(10, 9, 2, 0, 6'h06)};
    load_prog();
    poke(32'hBFC0_0028, 32'h0000_00C0);
    poke(32'hBFC0_002C, 32'h0000_0005);
    run_prog("srlv", 0, 1, 32'h6);
    run_prog("srlv_wait", 3, 1, 32'h6);

    prog = '{enc_i(6'h0F, 0, 9, 16'h8000), enc_i(6'h09, 0, 10, 16'h0004),
             enc_r(0, 0, 0, 0, 6'h08), enc_r(10, 9, 2, 0, 6'h07)};
    load_prog();
    run_prog("srav", 0, 1, 32'hF800_0000);

    prog = '{enc_r(0, 0, 0, 0, 6'h08), enc_i(6'h09, 0, 2, 16'h0007)};
    load_prog();
    run_prog("delay_slot", 0, 1, 32'h7);

    prog = '{enc_i(6'h0F, 0, 3, 16'hBFC0), enc_i(6'h0F, 0, 4, 16'h1234),
             enc_i(6'h09, 4, 4, 16'h5678), enc_i(6'h2B, 3, 4, 16'h0100),
             enc_i(6'h23, 3, 2, 16'h0100), enc_r(0, 0, 0, 0, 6'h08), 32'h0};
    load_prog();
    run_prog("sw_lw", 0, 1, 32'h1234_5678);
    load_prog();
    run_prog("sw_lw_wait", 3, 1, 32'h1234_5678);

    // Reset lands while the store is stalled on the bus.
    prog = '{enc_i(6'h0F, 0, 3, 16'hBFC0), enc_i(6'h09, 0, 4, 16'h0055),
             enc_i(6'h2B, 3, 4, 16'h0100), enc_r(0, 0, 0, 0, 6'h08), 32'h0};
    load_prog();
    stall_cfg = 3;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (write) found = 1;
    end
    check("midrst_store_seen", 32'(found), 32'h1);
    #1 reset = 1'b0;
    #1 check("midrst_write_drop", 32'(write), 32'h0);
    repeat (3) @(negedge clk);
    check("midrst_no_store", 32'(mem.exists(32'hBFC0_0100)), 32'h0);
    run_prog("midrst_rerun", 0, 1, 32'h0);

    for (int t = 0; t < 6; t++) begin
      gen_random(40);
      load_prog();
      run_prog($sformatf("rand%0d", t), int'($urandom_range(0, 3)), 0, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
